// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Arbitrates two requesters onto one shared combinational ALU. One operation
// is in flight at a time: IDLE accepts a request, EXEC captures the ALU result,
// RESP holds the result until the consumer takes it. When both requesters are
// valid in IDLE, the priority pointer picks; after each completed response the
// pointer moves to the requester that was not just served.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid / reqN_ready     requester N handshake (ready is combinational)
//   reqN_a, reqN_b              requester N operands
//   reqN_ctrl                   {A_or_L, S_or_U, OpCode[1:0]}
//   resp_valid / resp_ready     response handshake
//   resp_id, resp_data          owner and registered result of the response
//   alu_a, alu_b, alu_a_or_l,
//   alu_s_or_u, alu_opcode      operands/modes to the shared ALU (registered)
//   alu_result                  combinational result from the shared ALU
//   busy                        high whenever the FSM is not in IDLE
//   ops_done                    count of completed responses (wraps)
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_a_or_l,
    output logic             alu_s_or_u,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,

    output logic             busy,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic               ptr_q,        ptr_d;
    logic [WIDTH-1:0]   a_q,          a_d;
    logic [WIDTH-1:0]   b_q,          b_d;
    logic [3:0]         ctrl_q,       ctrl_d;
    logic               gnt_q,        gnt_d;
    logic [WIDTH-1:0]   resp_data_q,  resp_data_d;
    logic               resp_id_q,    resp_id_d;
    logic [15:0]        ops_done_q,   ops_done_d;
    logic               resp_valid_q, resp_valid_d;
    logic               busy_q,       busy_d;

    logic idle;
    logic any_valid;
    logic gnt_sel;   // index of the requester that would be granted now
    logic accept;

    assign idle      = (state_q == IDLE);
    assign any_valid = req0_valid | req1_valid;
    // Both valid: pointer decides. Otherwise the lone valid one (req1 iff valid).
    assign gnt_sel   = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    assign accept    = idle & any_valid;

    // NOTE: rst_n gates the readies combinationally so they read 0 while reset
    // is held, even though the state register already sits at IDLE.
    assign req0_ready = rst_n & accept & ~gnt_sel;
    assign req1_ready = rst_n & accept &  gnt_sel;

    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_d      = ctrl_q;
        gnt_d       = gnt_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        ops_done_d  = ops_done_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = gnt_sel ? req1_a    : req0_a;
                    b_d     = gnt_sel ? req1_b    : req0_b;
                    ctrl_d  = gnt_sel ? req1_ctrl : req0_ctrl;
                    gnt_d   = gnt_sel;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d = alu_result;
                resp_id_d   = gnt_q;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    ptr_d      = ~resp_id_q;
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with state_q.
        resp_valid_d = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= '0;
            gnt_q        <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            ops_done_q   <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctrl_q       <= ctrl_d;
            gnt_q        <= gnt_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            ops_done_q   <= ops_done_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_a_or_l = ctrl_q[3];
    assign alu_s_or_u = ctrl_q[2];
    assign alu_opcode = ctrl_q[1:0];

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;
    assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter through directed scenarios and a randomized phase. A
// behavioural ALU closes the loop on alu_*/alu_result. The reference model
// tracks one in-flight operation by its age in cycles since acceptance and
// predicts readies, busy, response timing, payload and ops_done every cycle.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_a_or_l, alu_s_or_u;
    logic [1:0]  alu_opcode;
    logic        busy;
    logic [15:0] ops_done;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_a_or_l (alu_a_or_l),
        .alu_s_or_u (alu_s_or_u),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {A_or_L, S_or_U, OpCode}; A_or_L=1 selects arithmetic.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] ctrl);
        case ({ctrl[3], ctrl[1:0]})
            3'b100:  alu_fn = a + b;
            3'b101:  alu_fn = a - b;
            3'b110:  alu_fn = ctrl[2] ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
            3'b111:  alu_fn = a ^ ~b;
            3'b000:  alu_fn = a & b;
            3'b001:  alu_fn = a | b;
            3'b010:  alu_fn = a ^ b;
            default: alu_fn = ~(a | b);
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, {alu_a_or_l, alu_s_or_u, alu_opcode});

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: at most one operation outstanding, identified by the
    // number of cycles since it was accepted (result visible from age 2 on).
    bit          m_inflight = 1'b0;
    int          m_age      = 0;
    bit          m_ptr      = 1'b0;
    bit          m_id       = 1'b0;
    logic [31:0] m_a        = '0;
    logic [31:0] m_b        = '0;
    logic [3:0]  m_ctrl     = '0;
    logic [15:0] m_done     = '0;
    int          g0 = 0, g1 = 0;

    task automatic model_reset();
        m_inflight = 1'b0;
        m_age      = 0;
        m_ptr      = 1'b0;
        m_id       = 1'b0;
        m_a        = '0;
        m_b        = '0;
        m_ctrl     = '0;
        m_done     = '0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] c0, input logic v1, input logic [31:0] a1,
                        input logic [31:0] b1, input logic [3:0] c1, input logic rr);
        bit e_r0, e_r1, e_rv;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        resp_ready = rr;
        @(negedge clk);
        e_r0 = !m_inflight && v0 && (!v1 || !m_ptr);
        e_r1 = !m_inflight && v1 && (!v0 ||  m_ptr);
        e_rv = m_inflight && (m_age >= 2);
        check("req0_ready", req0_ready, e_r0);
        check("req1_ready", req1_ready, e_r1);
        check("busy",       busy,       m_inflight);
        check("resp_valid", resp_valid, e_rv);
        check("ops_done",   ops_done,   m_done);
        check("alu_a",      alu_a,      m_a);
        check("alu_b",      alu_b,      m_b);
        check("alu_ctrl",   {alu_a_or_l, alu_s_or_u, alu_opcode}, m_ctrl);
        if (e_rv) begin
            check("resp_id",   resp_id,   m_id);
            check("resp_data", resp_data, alu_fn(m_a, m_b, m_ctrl));
        end
        if (req0_ready && v0) g0++;
        if (req1_ready && v1) g1++;
        @(posedge clk);
        if (e_rv && rr) begin
            m_inflight = 1'b0;
            m_ptr      = !m_id;
            m_done     = m_done + 16'd1;
        end else if (m_inflight) begin
            m_age++;
        end
        if (e_r0 || e_r1) begin
            m_inflight = 1'b1;
            m_age      = 1;
            m_id       = e_r1;
            m_a        = e_r1 ? a1 : a0;
            m_b        = e_r1 ? b1 : b0;
            m_ctrl     = e_r1 ? c1 : c0;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req0_ready"}, req0_ready, 1'b0);
        check({tag, "_req1_ready"}, req1_ready, 1'b0);
        check({tag, "_resp_valid"}, resp_valid, 1'b0);
        check({tag, "_busy"},       busy,       1'b0);
        check({tag, "_ops_done"},   ops_done,   16'd0);
        check({tag, "_resp_data"},  resp_data,  32'd0);
        check({tag, "_resp_id"},    resp_id,    1'b0);
        check({tag, "_alu_a"},      alu_a,      32'd0);
        check({tag, "_alu_b"},      alu_b,      32'd0);
        check({tag, "_alu_ctrl"},   {alu_a_or_l, alu_s_or_u, alu_opcode}, 4'd0);
    endtask

    // Entered at posedge+1; asserts reset mid-cycle with both requesters valid.
    task automatic do_reset(input string tag);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_ctrl = '0;
        resp_ready = 1'b0;

        // Power-on reset with both requesters asking: all outputs at zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Single op right after reset: 5 + 3 = 8, response two cycles later.
        repeat (3) step(1'b1, 32'd5, 32'd3, 4'b1000, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        check("single_resp_data", resp_data, 32'd8);
        check("single_resp_id",   resp_id,   1'b0);
        check("single_ops_done",  ops_done,  16'd1);
        step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);

        // Contention from a fresh pointer: grants must alternate 0,1,0,1.
        do_reset("rst_a");
        g0 = 0;
        g1 = 0;
        for (int i = 0; i < 12; i++)
            step(1'b1, 32'h100 + i, 32'h7, 4'b1001, 1'b1, 32'h200 + i, 32'h9, 4'b0010, 1'b1);
        check("contend_grants0", g0, 2);
        check("contend_grants1", g1, 2);
        check("contend_ops_done", ops_done, 16'd4);

        // Backpressure: five RESP cycles held, both still asking, no readies.
        step(1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 4'b0001, 1'b1, 32'h1, 32'h2, 4'b1110, 1'b0);
        step(1'b1, 32'h0, 32'h0, 4'd0, 1'b1, 32'h0, 32'h0, 4'd0, 1'b0);
        repeat (5) step(1'b1, 32'h0, 32'h0, 4'd0, 1'b1, 32'h0, 32'h0, 4'd0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
        check("bp_idle_busy", busy, 1'b0);

        // Reset while in EXEC: operation discarded, nothing comes out.
        step(1'b1, 32'h55, 32'h66, 4'b1000, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
        check("midrst_busy_exec", busy, 1'b1);
        do_reset("midrst");
        repeat (4) step(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
        check("midrst_ops_done", ops_done, 16'd0);

        // Randomized traffic, including valids that drop before acceptance.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0));

        // Wrap: drain, preload the counter, then complete three operations.
        repeat (4) step(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
        force dut.ops_done_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.ops_done_q;
        m_done = 16'hFFFE;
        check("wrap_preload", ops_done, 16'hFFFE);
        repeat (3) step(1'b0, 32'h0, 32'h0, 4'd0, 1'b1, 32'h3, 32'h4, 4'b1000, 1'b1);
        check("wrap_ffff", ops_done, 16'hFFFF);
        repeat (3) step(1'b0, 32'h0, 32'h0, 4'd0, 1'b1, 32'h5, 32'h6, 4'b0011, 1'b1);
        check("wrap_zero", ops_done, 16'h0000);
        repeat (3) step(1'b1, 32'h7, 32'h8, 4'b1101, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
        check("wrap_one", ops_done, 16'h0001);
        step(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_ctrl  input  4  requester 0 control {A_or_L, S_or_U, OpCode[1:0]}.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same as REQ-004..REQ-007, for requester 1.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_id  output  1  requester index that owns resp_data.
REQ-012 resp_data  output  32  registered ALU result.
REQ-013 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-014 alu_a_or_l, alu_s_or_u  output  1 each  ALU mode selects.
REQ-015 alu_opcode  output  2  ALU operation select.
REQ-016 alu_result  input  32  combinational result from the shared ALU.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 ops_done  output  16  count of completed responses.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-020 In IDLE with no reqN_valid, the FSM SHALL remain in IDLE.
REQ-021 In IDLE, the grant SHALL go to the only valid requester, or to the requester named by the priority pointer if both are valid.
REQ-022 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; at most one ready is high per cycle.
REQ-023 On acceptance (valid && ready), the block SHALL latch operands, ctrl and the grant index into internal registers and move to EXEC.
REQ-024 alu_a, alu_b, alu_a_or_l, alu_s_or_u and alu_opcode SHALL always be driven from the latched registers; they hold between operations.
REQ-025 In EXEC, the block SHALL capture alu_result into resp_data, set resp_id to the latched grant, and move to RESP; EXEC lasts exactly one cycle.
REQ-026 In RESP, resp_valid=1 and resp_data/resp_id SHALL stay stable until resp_ready=1.
REQ-027 On resp_valid && resp_ready, the block SHALL return to IDLE, set the priority pointer to the requester not just served, and increment ops_done.
REQ-028 ops_done SHALL wrap from 0xFFFF to 0x0000.
REQ-029 Latency: acceptance in cycle N gives resp_valid in cycle N+2; with resp_ready held high, throughput is one operation per 3 cycles.
REQ-030 New requests are not accepted outside IDLE, including in the cycle RESP completes; the earliest next acceptance is the following cycle.
REQ-031 A requester that drops valid before acceptance SHALL lose nothing, and the pointer SHALL be unchanged.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously set state to IDLE, priority pointer to 0, all latched registers, resp_data, resp_id and ops_done to 0, and resp_valid, busy and both readies to 0.
REQ-033 A reset during EXEC or RESP SHALL discard the in-flight operation, produce no response and leave ops_done unchanged from 0.
REQ-034 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-035 Single op: req0 a=5, b=3, ctrl=arith add, alu_result model=8, resp_ready=1 -> req0_ready pulses in cycle N; resp_valid, resp_id=0, resp_data=8 in cycle N+2; ops_done=1.
REQ-036 Contention: both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1; each response carries the matching resp_id; no requester starves.
REQ-037 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_data and resp_id stay stable, no readies assert; release -> one-cycle handshake, then IDLE.
REQ-038 Mid-op reset: rst_n low during EXEC -> all outputs 0 immediately; no response after release; ops_done=0.
REQ-039 Wrap: force 65536 completions (or preload via hierarchy) -> ops_done goes 0xFFFF->0x0000; busy=0 in IDLE and busy=1 in EXEC and RESP throughout.
